axi_master_w: RTL and testbench

- Master-side (initiator) AXI3 write-data channel controller for the MME simulation environment.
- Pops one write-address descriptor (address, ID, length) from an external AW-descriptor FIFO, then drives 1–16 W beats with `wid`, `wstrb`, `wdata` and `wlast`.
- After the last beat is accepted, pushes the burst ID into an external B-tracking FIFO.
- Sits between the AW-channel master control and the DUT's slave write-data port.

---
 rtl/axi_master_w_pkg.sv | 30 +++
 rtl/axi_master_w.sv | 150 +++++++++++++++
 tb/tb_axi_master_w.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_master_w_pkg.sv
// axi_master_w_pkg
//   Shared definitions for the AXI3 master-side data-channel controllers.
//   - Default AXI widths (AXI_DATA_WIDTH, AXI_ID_WIDTH). A project-wide
//     typedef header may define them earlier; otherwise the fallbacks below apply.
//   - Burst state encoding (S_IDLE=0, S_BURST=1, S_PUSH=2, 2 bits), kept here
//     so the R-side master can reuse the idle/burst naming.
//   No ports; this file is a package only.

`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 128
`endif

`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

package axi_master_w_pkg;

    localparam int DEF_DATA_WIDTH = `AXI_DATA_WIDTH;
    localparam int DEF_ID_WIDTH   = `AXI_ID_WIDTH;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_PUSH  = 2'd2
    } burst_state_e;

endpackage

// File: rtl/axi_master_w.sv
// axi_master_w
//   AXI3 master write-data channel controller. Pops one AW descriptor
//   (address, ID, beats-minus-one) from an external FIFO, drives 1..16 W beats
//   with full strobes, then pushes the burst ID into an external B-tracking
//   FIFO. At most one burst is in flight.
//
//   Optional feature macro: AXI_MASTER_W_DATA_EN
//     defined   : wdata_o / rdata_i exist; wdata_o = rdata_i during a burst.
//     undefined : both ports are removed (control-only benches).
//
//   Ports
//     clk, rst               clock, synchronous active-high reset
//     empty_i, rden_o        AW-descriptor FIFO status / pop
//     awaddr_i, awid_i,
//     awlen_i                head descriptor fields
//     wvalid_o, wid_o,
//     wdata_o, wstrb_o,
//     wlast_o, wready_i      W channel
//     raddr_o, rdata_i       beat address to the data source / its data
//     full_i, wren_o, bid_o  B-tracking FIFO status / push / pushed ID

module axi_master_w
    import axi_master_w_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = `AXI_DATA_WIDTH,
    parameter int ID_WIDTH   = `AXI_ID_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    empty_i,
    output logic                    rden_o,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    input  logic [ID_WIDTH-1:0]     awid_i,
    input  logic [3:0]              awlen_i,
    output logic                    wvalid_o,
    output logic [ID_WIDTH-1:0]     wid_o,
`ifdef AXI_MASTER_W_DATA_EN
    output logic [DATA_WIDTH-1:0]   wdata_o,
`endif
    output logic [DATA_WIDTH/8-1:0] wstrb_o,
    output logic                    wlast_o,
    input  logic                    wready_i,
    output logic [ADDR_WIDTH-1:0]   raddr_o,
`ifdef AXI_MASTER_W_DATA_EN
    input  logic [DATA_WIDTH-1:0]   rdata_i,
`endif
    input  logic                    full_i,
    output logic                    wren_o,
    output logic [ID_WIDTH-1:0]     bid_o
);

    localparam int                    STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(STRB_WIDTH);

    burst_state_e          state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg,  addr_next;
    logic [ID_WIDTH-1:0]   id_reg,    id_next;
    logic [3:0]            cnt_reg,   cnt_next;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            addr_reg  <= '0;
            id_reg    <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            id_reg    <= id_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        id_next    = id_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (!empty_i) begin
                    addr_next  = awaddr_i;
                    id_next    = awid_i;
                    cnt_next   = awlen_i;
                    state_next = S_BURST;
                end
            end
            S_BURST: begin
                // wvalid_o is always high here, so wready_i alone is the handshake.
                if (wready_i) begin
                    // Address wraps modulo 2^ADDR_WIDTH by plain truncation.
                    addr_next = addr_reg + BEAT_BYTES;
                    if (cnt_reg == 4'd0) begin
                        state_next = S_PUSH;
                    end else begin
                        cnt_next = cnt_reg - 4'd1;
                    end
                end
            end
            S_PUSH: begin
                if (!full_i) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs: pure decodes of registered state and current inputs.
    always_comb begin
        rden_o   = 1'b0;
        wvalid_o = 1'b0;
        wid_o    = '0;
        wstrb_o  = '0;
        wlast_o  = 1'b0;
        raddr_o  = '0;
        wren_o   = 1'b0;
        bid_o    = '0;
`ifdef AXI_MASTER_W_DATA_EN
        wdata_o  = '0;
`endif
        case (state_reg)
            S_IDLE: begin
                rden_o = !empty_i;
            end
            S_BURST: begin
                wvalid_o = 1'b1;
                wid_o    = id_reg;
                wstrb_o  = '1;
                wlast_o  = (cnt_reg == 4'd0);
                raddr_o  = addr_reg;
`ifdef AXI_MASTER_W_DATA_EN
                wdata_o  = rdata_i;
`endif
            end
            S_PUSH: begin
                bid_o  = id_reg;
                wren_o = !full_i;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_axi_master_w.sv
// tb_axi_master_w
//   Self-checking bench for axi_master_w. The bench plays the AW-descriptor
//   FIFO, the W slave and the B-tracking FIFO. Expected beats are derived from
//   each descriptor as a list: beat i has address start + i*bytes (mod 2^16),
//   wlast only on beat awlen, followed by one push of the burst ID.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge.

module tb_axi_master_w;
    import axi_master_w_pkg::*;

    localparam int AW = 16;
    localparam int DW = DEF_DATA_WIDTH;
    localparam int IW = DEF_ID_WIDTH;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          empty_i = 1'b1;
    logic          rden_o;
    logic [AW-1:0] awaddr_i = '0;
    logic [IW-1:0] awid_i = '0;
    logic [3:0]    awlen_i = '0;
    logic          wvalid_o;
    logic [IW-1:0] wid_o;
    logic [SW-1:0] wstrb_o;
    logic          wlast_o;
    logic          wready_i = 1'b0;
    logic [AW-1:0] raddr_o;
    logic          full_i = 1'b0;
    logic          wren_o;
    logic [IW-1:0] bid_o;

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [DW-1:0] src_data(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        for (int i = 0; i < DW; i++) d[i] = a[i % AW] ^ (i % 3 == 0);
        return d;
    endfunction

`ifdef AXI_MASTER_W_DATA_EN
    logic [DW-1:0] wdata_o;
    logic [DW-1:0] rdata_i;
    assign rdata_i = src_data(raddr_o);
`endif

    axi_master_w #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk      (clk),
        .rst      (rst),
        .empty_i  (empty_i),
        .rden_o   (rden_o),
        .awaddr_i (awaddr_i),
        .awid_i   (awid_i),
        .awlen_i  (awlen_i),
        .wvalid_o (wvalid_o),
        .wid_o    (wid_o),
`ifdef AXI_MASTER_W_DATA_EN
        .wdata_o  (wdata_o),
`endif
        .wstrb_o  (wstrb_o),
        .wlast_o  (wlast_o),
        .wready_i (wready_i),
        .raddr_o  (raddr_o),
`ifdef AXI_MASTER_W_DATA_EN
        .rdata_i  (rdata_i),
`endif
        .full_i   (full_i),
        .wren_o   (wren_o),
        .bid_o    (bid_o)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, got %0d vectors", vectors);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [3:0] len);
        empty_i  = 1'b0;
        awaddr_i = a;
        awid_i   = id;
        awlen_i  = len;
    endtask

    task automatic test_reset();
        tick(); rst = 1'b1; empty_i = 1'b1; full_i = 1'b1; wready_i = 1'b1;
        tick(); rst = 1'b0; full_i = 1'b0; wready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if ({rden_o, wvalid_o, wlast_o, wren_o, wid_o, bid_o, raddr_o, wstrb_o} !== '0) begin
                miscompares++;
                $display("FAIL reset_idle: got rden=%b wvalid=%b wlast=%b wren=%b wid=%h bid=%h raddr=%h wstrb=%h, required all 0",
                         rden_o, wvalid_o, wlast_o, wren_o, wid_o, bid_o, raddr_o, wstrb_o);
            end
`ifdef AXI_MASTER_W_DATA_EN
            vectors++;
            if (wdata_o !== '0) begin
                miscompares++;
                $display("FAIL reset_wdata: got %h, required 0", wdata_o);
            end
`endif
            tick();
        end
    endtask

    task automatic test_single_beat();
        present(16'h0100, IW'(3), 4'd0); wready_i = 1'b1;
        @(negedge clk);
        vectors++;
        if ({rden_o, wvalid_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL single_pop: got rden=%b wvalid=%b, required 1 0", rden_o, wvalid_o);
        end
        tick(); empty_i = 1'b1;
        @(negedge clk);
        vectors++;
        if ({wvalid_o, wlast_o, wid_o, raddr_o, wstrb_o, rden_o, wren_o} !==
            {1'b1, 1'b1, IW'(3), 16'h0100, {SW{1'b1}}, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL single_beat: got wvalid=%b wlast=%b wid=%h raddr=%h wstrb=%h rden=%b wren=%b, required 1 1 3 0100 all-ones 0 0",
                     wvalid_o, wlast_o, wid_o, raddr_o, wstrb_o, rden_o, wren_o);
        end
`ifdef AXI_MASTER_W_DATA_EN
        vectors++;
        if (wdata_o !== src_data(16'h0100)) begin
            miscompares++;
            $display("FAIL single_wdata: got %h, required %h", wdata_o, src_data(16'h0100));
        end
`endif
        tick();
        @(negedge clk);
        vectors++;
        if ({wren_o, bid_o, wvalid_o, wstrb_o} !== {1'b1, IW'(3), 1'b0, SW'(0)}) begin
            miscompares++;
            $display("FAIL single_push: got wren=%b bid=%h wvalid=%b wstrb=%h, required 1 3 0 0", wren_o, bid_o, wvalid_o, wstrb_o);
        end
        tick(); wready_i = 1'b0;
        @(negedge clk);
        vectors++;
        if ({wren_o, wvalid_o, rden_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL single_after: got wren=%b wvalid=%b rden=%b, required 0 0 0", wren_o, wvalid_o, rden_o);
        end
    endtask

    task automatic test_16beat();
        int pops = 0;
        int pushes = 0;
        logic [IW-1:0] id;
        id = IW'($urandom);
        tick(); present(16'h0000, id, 4'd15); wready_i = 1'b1;
        @(negedge clk);
        pops += int'(rden_o);
        for (int i = 0; i < 16; i++) begin
            tick(); empty_i = 1'b1;
            @(negedge clk);
            pops += int'(rden_o); pushes += int'(wren_o);
            vectors++;
            if ({wvalid_o, wlast_o, wid_o, raddr_o} !== {1'b1, (i == 15), id, AW'(i * SW)}) begin
                miscompares++;
                $display("FAIL burst16_beat%0d: got wvalid=%b wlast=%b wid=%h raddr=%h, required 1 %b %h %h",
                         i, wvalid_o, wlast_o, wid_o, raddr_o, (i == 15), id, AW'(i * SW));
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            pops += int'(rden_o); pushes += int'(wren_o);
            if (k == 0) begin
                vectors++;
                if ({wren_o, bid_o} !== {1'b1, id}) begin
                    miscompares++;
                    $display("FAIL burst16_push: got wren=%b bid=%h, required 1 %h", wren_o, bid_o, id);
                end
            end
        end
        vectors++;
        if (pops != 1 || pushes != 1) begin
            miscompares++;
            $display("FAIL burst16_counts: got pops=%0d pushes=%0d, required 1 1", pops, pushes);
        end
        wready_i = 1'b0;
    endtask

    task automatic test_backpressure();
        int beats = 0;
        tick(); present(16'h1000, IW'(6), 4'd3); wready_i = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            tick(); empty_i = 1'b1; wready_i = (k % 2 == 1);
            @(negedge clk);
            vectors++;
            if ({wvalid_o, wlast_o, raddr_o, wren_o} !== {1'b1, (beats == 3), AW'(16'h1000 + beats * SW), 1'b0}) begin
                miscompares++;
                $display("FAIL backpressure_cyc%0d: got wvalid=%b wlast=%b raddr=%h wren=%b, required 1 %b %h 0",
                         k, wvalid_o, wlast_o, raddr_o, wren_o, (beats == 3), AW'(16'h1000 + beats * SW));
            end
            if (wready_i) beats++;
        end
        tick(); wready_i = 1'b0;
        @(negedge clk);
        vectors++;
        if ({wvalid_o, wren_o, bid_o} !== {1'b0, 1'b1, IW'(6)}) begin
            miscompares++;
            $display("FAIL backpressure_push: got wvalid=%b wren=%b bid=%h, required 0 1 6", wvalid_o, wren_o, bid_o);
        end
        tick();
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_addr;
        present(16'hFFF0, IW'(1), 4'd1); wready_i = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            tick(); empty_i = 1'b1;
            @(negedge clk);
            exp_addr = AW'(32'h0000_FFF0 + i * SW);
            vectors++;
            if ({wvalid_o, raddr_o, wlast_o} !== {1'b1, exp_addr, (i == 1)}) begin
                miscompares++;
                $display("FAIL wrap_beat%0d: got wvalid=%b raddr=%h wlast=%b, required 1 %h %b", i, wvalid_o, raddr_o, wlast_o, exp_addr, (i == 1));
            end
        end
        tick(); wready_i = 1'b0;
        @(negedge clk);
        tick();
    endtask

    task automatic test_full_back_to_back();
        present(16'h0300, IW'(5), 4'd1); wready_i = 1'b1;
        @(negedge clk);
        vectors++;
        if (rden_o !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_popA: got rden=%b, required 1", rden_o);
        end
        tick(); present(16'h0500, IW'(9), 4'd0);   // FIFO advanced to B
        for (int i = 0; i < 2; i++) begin
            if (i > 0) tick();
            @(negedge clk);
            vectors++;
            if ({wvalid_o, wid_o, rden_o} !== {1'b1, IW'(5), 1'b0}) begin
                miscompares++;
                $display("FAIL b2b_beatA%0d: got wvalid=%b wid=%h rden=%b, required 1 5 0", i, wvalid_o, wid_o, rden_o);
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick(); full_i = 1'b1;
            @(negedge clk);
            vectors++;
            if ({wren_o, bid_o, rden_o, wvalid_o} !== {1'b0, IW'(5), 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL b2b_full%0d: got wren=%b bid=%h rden=%b wvalid=%b, required 0 5 0 0", k, wren_o, bid_o, rden_o, wvalid_o);
            end
        end
        tick(); full_i = 1'b0;
        @(negedge clk);
        vectors++;
        if ({wren_o, bid_o, rden_o} !== {1'b1, IW'(5), 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_pushA: got wren=%b bid=%h rden=%b, required 1 5 0", wren_o, bid_o, rden_o);
        end
        tick();
        @(negedge clk);
        vectors++;
        if ({rden_o, wvalid_o, wren_o} !== 3'b100) begin
            miscompares++;
            $display("FAIL b2b_popB: got rden=%b wvalid=%b wren=%b, required 1 0 0", rden_o, wvalid_o, wren_o);
        end
        tick(); empty_i = 1'b1;
        @(negedge clk);
        vectors++;
        if ({wvalid_o, wid_o, raddr_o, wlast_o} !== {1'b1, IW'(9), 16'h0500, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_beatB: got wvalid=%b wid=%h raddr=%h wlast=%b, required 1 9 0500 1", wvalid_o, wid_o, raddr_o, wlast_o);
        end
        tick();
        @(negedge clk);
        vectors++;
        if ({wren_o, bid_o} !== {1'b1, IW'(9)}) begin
            miscompares++;
            $display("FAIL b2b_pushB: got wren=%b bid=%h, required 1 9", wren_o, bid_o);
        end
        tick(); wready_i = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        present(16'h0200, IW'(6), 4'd3); wready_i = 1'b1;
        @(negedge clk);
        tick(); empty_i = 1'b1;                 // beat 1
        @(negedge clk);
        tick(); rst = 1'b1;                     // beat 2, reset sampled at its end
        @(negedge clk);
        vectors++;
        if ({wvalid_o, raddr_o} !== {1'b1, AW'(16'h0200 + SW)}) begin
            miscompares++;
            $display("FAIL rstmid_beat2: got wvalid=%b raddr=%h, required 1 %h", wvalid_o, raddr_o, AW'(16'h0200 + SW));
        end
        for (int k = 0; k < 4; k++) begin
            tick(); rst = 1'b0;
            @(negedge clk);
            vectors++;
            if ({wvalid_o, wren_o, raddr_o, wstrb_o} !== '0) begin
                miscompares++;
                $display("FAIL rstmid_quiet%0d: got wvalid=%b wren=%b raddr=%h wstrb=%h, required all 0", k, wvalid_o, wren_o, raddr_o, wstrb_o);
            end
        end
        tick(); present(16'h0040, IW'(7), 4'd0);
        @(negedge clk);
        vectors++;
        if (rden_o !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_pop: got rden=%b, required 1", rden_o);
        end
        tick(); empty_i = 1'b1;
        @(negedge clk);
        vectors++;
        if ({wvalid_o, wid_o, raddr_o, wlast_o} !== {1'b1, IW'(7), 16'h0040, 1'b1}) begin
            miscompares++;
            $display("FAIL rstmid_beat: got wvalid=%b wid=%h raddr=%h wlast=%b, required 1 7 0040 1", wvalid_o, wid_o, raddr_o, wlast_o);
        end
        tick();
        @(negedge clk);
        vectors++;
        if ({wren_o, bid_o} !== {1'b1, IW'(7)}) begin
            miscompares++;
            $display("FAIL rstmid_push: got wren=%b bid=%h, required 1 7", wren_o, bid_o);
        end
        tick(); wready_i = 1'b0;
    endtask

    task automatic test_random();
        logic [AW-1:0] a, exp_addr;
        logic [IW-1:0] id;
        logic [3:0]    len;
        int            beat, cyc, nfull, gap;
        for (int b = 0; b < 25; b++) begin
            a = AW'($urandom); id = IW'($urandom); len = 4'($urandom);
            present(a, id, len); wready_i = 1'($urandom); full_i = 1'($urandom);
            @(negedge clk);
            vectors++;
            if ({rden_o, wvalid_o} !== 2'b10) begin
                miscompares++;
                $display("FAIL rand%0d_pop: got rden=%b wvalid=%b, required 1 0", b, rden_o, wvalid_o);
            end
            beat = 0; cyc = 0;
            while (beat <= int'(len) && cyc < 80) begin
                tick();
                // Descriptor FIFO now shows random junk; it must be ignored.
                empty_i = 1'($urandom); awaddr_i = AW'($urandom); awid_i = IW'($urandom);
                wready_i = ($urandom_range(0, 3) != 0); full_i = 1'($urandom);
                @(negedge clk);
                exp_addr = AW'(int'(a) + beat * SW);
                vectors++;
                if ({wvalid_o, wlast_o, wid_o, raddr_o, wstrb_o, rden_o, wren_o} !==
                    {1'b1, (beat == int'(len)), id, exp_addr, {SW{1'b1}}, 1'b0, 1'b0}) begin
                    miscompares++;
                    $display("FAIL rand%0d_beat%0d: got wvalid=%b wlast=%b wid=%h raddr=%h wstrb=%h rden=%b wren=%b, required 1 %b %h %h all-ones 0 0",
                             b, beat, wvalid_o, wlast_o, wid_o, raddr_o, wstrb_o, rden_o, wren_o, (beat == int'(len)), id, exp_addr);
                end
`ifdef AXI_MASTER_W_DATA_EN
                vectors++;
                if (wdata_o !== src_data(exp_addr)) begin
                    miscompares++;
                    $display("FAIL rand%0d_wdata%0d: got %h, required %h", b, beat, wdata_o, src_data(exp_addr));
                end
`endif
                if (wready_i) beat++;
                cyc++;
            end
            if (beat <= int'(len)) begin
                vectors++;
                miscompares++;
                $display("FAIL rand%0d_timeout: got %0d beats, required %0d", b, beat, int'(len) + 1);
            end
            nfull = $urandom_range(0, 2);
            for (int k = 0; k <= nfull; k++) begin
                tick(); full_i = (k < nfull); empty_i = 1'($urandom); wready_i = 1'($urandom);
                @(negedge clk);
                vectors++;
                if ({wren_o, bid_o, wvalid_o, rden_o, wstrb_o} !== {(k == nfull), id, 1'b0, 1'b0, SW'(0)}) begin
                    miscompares++;
                    $display("FAIL rand%0d_push%0d: got wren=%b bid=%h wvalid=%b rden=%b wstrb=%h, required %b %h 0 0 0",
                             b, k, wren_o, bid_o, wvalid_o, rden_o, wstrb_o, (k == nfull), id);
                end
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                tick(); empty_i = 1'b1; full_i = 1'($urandom); wready_i = 1'($urandom);
                @(negedge clk);
                vectors++;
                if ({rden_o, wvalid_o, wren_o, bid_o} !== '0) begin
                    miscompares++;
                    $display("FAIL rand%0d_gap%0d: got rden=%b wvalid=%b wren=%b bid=%h, required all 0", b, g, rden_o, wvalid_o, wren_o, bid_o);
                end
            end
            tick();
        end
        empty_i = 1'b1; full_i = 1'b0; wready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_16beat();
        test_backpressure();
        test_wrap();
        test_full_back_to_back();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
